// File: rtl/conv_pkg.sv
// Shared definitions for the column SIPO scheduler.
//   state_e   : scheduler states (fill lanes, drain vectors, flush lanes)
//   cnt_width : width of a counter running 0..n-1 (at least 1 bit)
package conv_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FRAME_LEN_DEF = 50;
  localparam int CNT_W_DEF     = cnt_width(FRAME_LEN_DEF);

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MODULUS-1.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (wins over en_i)
//   en_i         : advance by one, wrapping from MODULUS-1 to 0
//   cnt_o        : current count
//   wrap_o       : en_i asserted while the count is MODULUS-1
module mod_counter
  import conv_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int W       = cnt_width(MODULUS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, wrap or increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/conv_sipo_sched.sv
// Column SIPO scheduler: steers FRAME_LEN-sample columns into COLUMN_LEN
// lane FIFOs, then drains FRAME_LEN column vectors downstream.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   valid_i/last_i/ready_o: upstream sample handshake, end-of-column marker
//   enq_o                 : one-hot lane enqueue strobes
//   deq_o, flush_o        : common dequeue strobe / clear pulse to lane FIFOs
//   valid_o/last_o/ready_i: downstream vector handshake, end-of-frame marker
//   err_len_o, err_clr_i  : sticky column-length error and its clear
//   frame_cnt_o           : completed-frame count (wraps)
module conv_sipo_sched
  import conv_pkg::*;
#(
  parameter int FRAME_LEN  = 50,
  parameter int COLUMN_LEN = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [COLUMN_LEN-1:0] enq_o,
  output logic                  deq_o,
  output logic                  flush_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i,
  output logic                  err_len_o,
  input  logic                  err_clr_i,
  output logic [15:0]           frame_cnt_o
);

  localparam int            CW   = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_e                  state_q, state_d;
  logic [COLUMN_LEN-1:0]   lane_sel_q;
  logic                    err_len_q;
  logic [15:0]             frame_cnt_q;

  logic [CW-1:0]           samp_cnt_s, drain_cnt_s;
  logic                    samp_wrap_s, drain_wrap_s;
  logic                    accept_s, deq_s, good_end_s, len_err_s, flush_s;

  assign accept_s   = valid_i && (state_q == ST_FILL);
  assign deq_s      = (state_q == ST_DRAIN) && ready_i;
  assign flush_s    = (state_q == ST_FLUSH);
  // samp_wrap_s already implies an accepted beat at the final sample
  assign good_end_s = samp_wrap_s && last_i;
  assign len_err_s  = accept_s && (last_i != (samp_cnt_s == LAST));

  // sample counter restarts on a bad column so the flush leaves it at 0
  mod_counter #(.MODULUS(FRAME_LEN), .W(CW)) u_samp_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (len_err_s || flush_s),
    .en_i   (accept_s),
    .cnt_o  (samp_cnt_s),
    .wrap_o (samp_wrap_s)
  );

  mod_counter #(.MODULUS(FRAME_LEN), .W(CW)) u_drain_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (1'b0),
    .en_i   (deq_s),
    .cnt_o  (drain_cnt_s),
    .wrap_o (drain_wrap_s)
  );

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (len_err_s) begin
          state_d = ST_FLUSH;
        end else if (good_end_s && lane_sel_q[COLUMN_LEN-1]) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (drain_wrap_s) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    flush_o = 1'b0;
    case (state_q)
      ST_FILL:  ready_o = 1'b1;
      ST_DRAIN: valid_o = 1'b1;
      ST_FLUSH: flush_o = 1'b1;
      default:  ready_o = 1'b0;
    endcase
  end

  assign enq_o  = lane_sel_q & {COLUMN_LEN{accept_s}};
  assign deq_o  = deq_s;
  assign last_o = valid_o && (drain_cnt_s == LAST);

  // lane select: rotate on each good column end; the rotation out of the
  // last lane lands back on lane 0 as the frame moves to DRAIN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_sel_q <= COLUMN_LEN'(1);
    end else if (flush_s) begin
      lane_sel_q <= COLUMN_LEN'(1);
    end else if (good_end_s) begin
      lane_sel_q <= (lane_sel_q << 1) | (lane_sel_q >> (COLUMN_LEN - 1));
    end else begin
      lane_sel_q <= lane_sel_q;
    end
  end

  // sticky length error; a new error wins over a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_len_q <= 1'b0;
    end else if (len_err_s) begin
      err_len_q <= 1'b1;
    end else if (err_clr_i) begin
      err_len_q <= 1'b0;
    end else begin
      err_len_q <= err_len_q;
    end
  end

  // completed-frame counter, bumped on the final drain handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= 16'd0;
    end else if (drain_wrap_s) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign err_len_o   = err_len_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/conv_sipo_sched.md
CONV_SIPO_SCHED -- requirements
Module: conv_sipo_sched

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 50, meaning samples per column and drain beats per frame.
REQ-002 SHALL have parameter COLUMN_LEN, default 8, meaning number of SIPO lanes (columns per frame).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk_i input 1: the single clock; all logic posedge clk_i.
REQ-005 SHALL have port rst_i input 1: asynchronous, active-high reset.
REQ-006 SHALL have port valid_i input 1: upstream sample valid.
REQ-007 SHALL have port last_i input 1: upstream end-of-column marker.
REQ-008 SHALL have port ready_o output 1: upstream may transfer.
REQ-009 SHALL have port enq_o output COLUMN_LEN: one-hot lane FIFO enqueue strobes.
REQ-010 SHALL have port deq_o output 1: common dequeue strobe to all lane FIFOs.
REQ-011 SHALL have port flush_o output 1: one-cycle clear pulse to all lane FIFOs.
REQ-012 SHALL have port valid_o output 1: downstream column vector valid.
REQ-013 SHALL have port last_o output 1: final vector of frame.
REQ-014 SHALL have port ready_i input 1: downstream ready.
REQ-015 SHALL have port err_len_o output 1: sticky column-length error.
REQ-016 SHALL have port err_clr_i input 1: clears err_len_o.
REQ-017 SHALL have port frame_cnt_o output 16: completed-frame count, wraps at 2^16.

Function
REQ-018 SHALL implement states FILL, DRAIN, FLUSH; accepted beat = valid_i && ready_o.
REQ-019 SHALL drive ready_o = 1 only in FILL; enq_o = lane_sel & {COLUMN_LEN{accepted beat}}, combinational.
REQ-020 SHALL track lane_sel (one-hot, lane 0 after reset) and sample count 0..FRAME_LEN-1.
REQ-021 SHALL treat an accepted beat at count FRAME_LEN-1 with last_i as good column end: count to 0, lane_sel rotates left.
REQ-022 SHALL, on good column end at lane COLUMN_LEN-1, enter DRAIN next cycle, lane_sel back to lane 0.
REQ-023 SHALL flag length error on accepted beat with last_i at count < FRAME_LEN-1, or without last_i at count FRAME_LEN-1; the beat is still enqueued.
REQ-024 SHALL on length error set err_len_o next cycle and enter FLUSH; FLUSH asserts flush_o one cycle, resets lane_sel and count, returns to FILL.
REQ-025 SHALL in DRAIN hold valid_o = 1, deq_o = valid_o && ready_i, advance drain count only on handshake.
REQ-026 SHALL assert last_o when valid_o and drain count = FRAME_LEN-1; last handshake returns to FILL and increments frame_cnt_o.
REQ-027 SHALL hold valid_o, deq_o stable while ready_i = 0 (no beat lost or duplicated).
REQ-028 SHALL give error set priority over err_clr_i in the same cycle; err_clr_i otherwise clears next cycle.
REQ-029 SHALL ignore valid_i/last_i outside FILL (ready_o = 0).

Reset
REQ-030 SHALL on rst_i asynchronously force FILL, lane 0, all counters 0, err_len_o 0, frame_cnt_o 0.
REQ-031 SHALL hold outputs after reset at: ready_o 1, enq_o 0, deq_o 0, flush_o 0, valid_o 0, last_o 0.
REQ-032 SHALL abandon any partial fill or drain on mid-operation reset; lane FIFOs are reset by the same rst_i.

Structure
REQ-033 SHALL place state encoding and the clog2-based counter-width constant in shared package conv_pkg.
REQ-034 SHALL instantiate sub-module mod_counter (parameterised modulus, enable, clear, wrap flag) for sample and drain counts.

Verification (FRAME_LEN=4, COLUMN_LEN=2)
REQ-035 SHALL test: 8 beats, last_i on beats 4,8 -> enq_o 01 x4 then 10 x4, DRAIN next cycle, ready_o 0.
REQ-036 SHALL test: DRAIN with ready_i=1 -> deq_o 4 consecutive cycles, last_o on 4th, frame_cnt_o 0->1, ready_o 1.
REQ-037 SHALL test: ready_i toggling 1,0,1,0... in DRAIN -> exactly 4 deq_o pulses, valid_o never drops early.
REQ-038 SHALL test: last_i on beat 2 -> err_len_o 1, one flush_o pulse, next fill starts lane 0.
REQ-039 SHALL test: error and err_clr_i same cycle -> err_len_o 1; err_clr_i alone later -> 0.
REQ-040 SHALL test: rst_i mid-DRAIN after 2 beats -> immediate valid_o 0, ready_o 1, frame_cnt_o unchanged at 0.
